// File: rtl/tetris_cmd_if.sv
// Move-command handshake between the scheduler (master) and the board-update engine (slave).
// The encoding of cmd_op is 00 LEFT, 01 RIGHT, 10 ROTATE, 11 DOWN.
interface tetris_cmd_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_op, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/tetris_move_scheduler.sv
// Synchronises/debounces the four game keys, runs the gravity timer and serialises
// every resulting move request onto a single valid/ready command port.
module tetris_move_scheduler #(
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int GRAVITY_CYCLES  = 25000000,
  parameter int FAST_CYCLES     = 2500000,
  parameter int CNT_W           = 25
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               key_rotate,
  input  logic               key_fall,
  tetris_cmd_if.master       cmd,
  output logic [3:0]         led
);

  // Bit index of every per-key vector equals the op code that key produces.
  typedef enum logic [1:0] {OP_LEFT = 2'd0, OP_RIGHT = 2'd1, OP_ROTATE = 2'd2, OP_DOWN = 2'd3} op_e;
  typedef enum logic {IDLE, ISSUE} state_e;

  localparam logic             POL       = 1'(KEY_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GRAV_LAST = CNT_W'(GRAVITY_CYCLES - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_CYCLES - 1);

  logic [3:0]       raw_keys, sync1, sync2, synced;
  logic [3:0]       deb, press;
  logic [CNT_W-1:0] db_cnt [4];
  logic [CNT_W-1:0] gcnt, period_last;
  logic             gtick, take;
  logic [3:0]       pending, pend_set, pend_clr, grant;
  op_e              win, op_q;
  state_e           state;
  logic             valid_q;

  assign raw_keys = {key_fall, key_rotate, key_right, key_left};

  // Sync flops reset to the released pin level so no false press follows reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= {4{POL}};
      sync2 <= {4{POL}};
    end else begin
      // NOTE: non-blocking here so sync2 takes the old sync1, giving two real flop stages.
      sync1 <= raw_keys;
      sync2 <= sync1;
    end
  end

  assign synced = sync2 ^ {4{POL}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= '0;
      // NOTE: the counter array is plain state, not a RAM, so it is reset like any flop.
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (synced[i] != deb[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            deb[i]    <= synced[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // A press event fires in the cycle the debounced level is about to rise.
  always_comb begin
    // NOTE: default first so every path assigns press and no latch is inferred.
    press = '0;
    for (int i = 0; i < 4; i++)
      press[i] = synced[i] && !deb[i] && (db_cnt[i] == DB_LAST);
  end

  assign led = deb;

  assign period_last = deb[OP_DOWN] ? FAST_LAST : GRAV_LAST;
  assign gtick       = enable && (gcnt >= period_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              gcnt <= '0;
    else if (!enable || gtick) gcnt <= '0;
    else                     gcnt <= gcnt + 1'b1;
  end

  always_comb begin
    win = OP_DOWN;
    if      (pending[OP_ROTATE]) win = OP_ROTATE;
    else if (pending[OP_LEFT])   win = OP_LEFT;
    else if (pending[OP_RIGHT])  win = OP_RIGHT;
  end

  assign grant    = 4'b0001 << win;
  assign take     = (state == IDLE) && enable && (|pending);
  assign pend_set = press | {gtick, 3'b000};
  assign pend_clr = take ? grant : 4'b0000;

  // Set is applied after clear so a same-cycle re-request survives the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pending <= '0;
    else if (!enable) pending <= '0;
    else              pending <= (pending & ~pend_clr) | pend_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      op_q    <= OP_LEFT;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            op_q    <= win;
            valid_q <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          // Held even when enable drops: a command once offered is never retracted.
          if (cmd.cmd_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_op    = op_q;

endmodule
